// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID skid stage.
package if_id_pkg;

    // Occupancy of the stage: no beat, one beat in main, or main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DEFAULT_INSTR_W = 32;
    localparam int DEFAULT_PC_W    = 8;

    // All-zero word used as the bubble handed to decode.
    localparam logic [DEFAULT_INSTR_W-1:0] DEFAULT_NOP_INSTR = '0;

    // One buffered beat is {instr, pc}.
    function automatic int entry_width(input int instr_w, input int pc_w);
        return instr_w + pc_w;
    endfunction

    localparam int DEFAULT_ENTRY_W = entry_width(DEFAULT_INSTR_W, DEFAULT_PC_W);

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc; stop once every bit is set; clear wins over inc.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with ready/valid on both sides, a one-beat skid
// entry, synchronous flush and a saturating stall-cycle counter.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int                   INSTR_W     = DEFAULT_INSTR_W,
    parameter int                   PC_W        = DEFAULT_PC_W,
    parameter logic [INSTR_W-1:0]   NOP_INSTR   = INSTR_W'(DEFAULT_NOP_INSTR),
    parameter int                   STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     instruction,
    input  logic [PC_W-1:0]        pcNext,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     instructionOut,
    output logic [PC_W-1:0]        pcNextOut,
    output logic [STALL_CNT_W-1:0] stallCycles
);

    localparam int ENTRY_W = entry_width(INSTR_W, PC_W);

    state_t             state;
    state_t             state_next;
    logic [ENTRY_W-1:0] skid_entry;
    logic               accept;
    logic               consume;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Occupancy register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next occupancy and which entry gets loaded from where; flush overrides all.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_next   = ONE;
                    end
                end
                ONE: begin
                    if (consume && accept) begin
                        load_main_in = 1'b1;
                    end else if (consume) begin
                        state_next = EMPTY;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (consume) begin
                        load_main_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Main entry, skid entry and registered in_ready; pcNextOut keeps its
    // value when the stage drains but takes the redirect PC on a flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instructionOut <= NOP_INSTR;
            pcNextOut      <= '0;
            skid_entry     <= '0;
            in_ready       <= 1'b1;
        end else begin
            if (flush) begin
                instructionOut <= NOP_INSTR;
                pcNextOut      <= pcNext;
            end else if (load_main_in) begin
                instructionOut <= instruction;
                pcNextOut      <= pcNext;
            end else if (load_main_skid) begin
                instructionOut <= skid_entry[ENTRY_W-1:PC_W];
                pcNextOut      <= skid_entry[PC_W-1:0];
            end else if (state_next == EMPTY) begin
                instructionOut <= NOP_INSTR;
            end
            if (load_skid) begin
                skid_entry <= {instruction, pcNext};
            end
            in_ready <= (state_next != FULL);
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_counter (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (out_valid & ~out_ready),
        .count (stallCycles)
    );

endmodule
